branch_resolve_tracker: RTL and testbench

- Sits at the consuming end of the 2-bit branch predictor's prediction interface.
- Records every issued prediction (address, predicted direction) in an in-order in-flight queue.
- When the pipeline resolves the oldest branch, compares the prediction with the actual outcome, then emits the predictor update (address, actual) and a mispredict/flush pulse.
- Keeps hit/miss statistics.

---
 rtl/branch_resolve_tracker.sv | 150 +++++++++++++++
 tb/tb_branch_resolve_tracker.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/branch_resolve_tracker.sv
// Tracks in-flight branch predictions in order, resolves the oldest against the
// actual outcome, and emits predictor updates, flush pulses and hit/miss stats.
module branch_resolve_tracker #(
  parameter int ADDRESS_BITS = 4,
  parameter int DEPTH        = 4,
  parameter int COUNT_BITS   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pred_valid,
  input  logic [ADDRESS_BITS-1:0]    pred_address,
  input  logic                       pred_taken,
  output logic                       pred_ready,
  input  logic                       resolve_valid,
  input  logic                       resolve_taken,
  output logic                       upd_valid,
  output logic [ADDRESS_BITS-1:0]    upd_address,
  output logic                       upd_taken,
  output logic                       mispredict,
  output logic [$clog2(DEPTH):0]     inflight,
  output logic [COUNT_BITS-1:0]      total_count,
  output logic [COUNT_BITS-1:0]      miss_count,
  output logic                       error
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]        inflight_q, inflight_d;
  logic                    upd_valid_q, upd_valid_d;
  logic [ADDRESS_BITS-1:0] upd_address_q, upd_address_d;
  logic                    upd_taken_q, upd_taken_d;
  logic                    mispredict_q, mispredict_d;
  logic [COUNT_BITS-1:0]   total_q, total_d, miss_q, miss_d;
  logic                    error_q, error_d;

  logic [ADDRESS_BITS-1:0] mem_addr_q  [DEPTH];
  logic                    mem_taken_q [DEPTH];

  logic push, pop, miss, err_evt, mem_we;

  function automatic logic [COUNT_BITS-1:0] sat_inc(input logic [COUNT_BITS-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign pred_ready = (state_q == RUN) && (inflight_q != FULL);
  assign push       = pred_valid && pred_ready;
  assign pop        = resolve_valid && (state_q == RUN) && (inflight_q != '0);
  assign err_evt    = resolve_valid && (state_q == RUN) && (inflight_q == '0);
  assign miss       = pop && (mem_taken_q[rd_ptr_q] != resolve_taken);
  // A mispredicting pop squashes the wrong-path push issued in the same cycle.
  assign mem_we     = push && !miss;

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    inflight_d    = inflight_q;
    upd_valid_d   = 1'b0;
    upd_address_d = upd_address_q;
    upd_taken_d   = upd_taken_q;
    mispredict_d  = 1'b0;
    total_d       = total_q;
    miss_d        = miss_q;
    error_d       = error_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d      = rd_ptr_q + 1'b1;
      upd_valid_d   = 1'b1;
      upd_address_d = mem_addr_q[rd_ptr_q];
      upd_taken_d   = resolve_taken;
      total_d       = sat_inc(total_q);
    end
    case ({push, pop})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase

    if (miss) begin
      mispredict_d = 1'b1;
      miss_d       = sat_inc(miss_q);
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      inflight_d   = '0;
      state_d      = FLUSH;
    end
    if (err_evt) begin
      error_d = 1'b1;
    end
    // Flush window is a single cycle regardless of inputs.
    if (state_q == FLUSH) begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= RUN;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      inflight_q    <= '0;
      upd_valid_q   <= 1'b0;
      upd_address_q <= '0;
      upd_taken_q   <= 1'b0;
      mispredict_q  <= 1'b0;
      total_q       <= '0;
      miss_q        <= '0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      inflight_q    <= inflight_d;
      upd_valid_q   <= upd_valid_d;
      upd_address_q <= upd_address_d;
      upd_taken_q   <= upd_taken_d;
      mispredict_q  <= mispredict_d;
      total_q       <= total_d;
      miss_q        <= miss_d;
      error_q       <= error_d;
    end
  end

  // Queue payload is data only; validity is carried by the pointers/occupancy.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_addr_q[wr_ptr_q]  <= pred_address;
      mem_taken_q[wr_ptr_q] <= pred_taken;
    end
  end

  assign upd_valid   = upd_valid_q;
  assign upd_address = upd_address_q;
  assign upd_taken   = upd_taken_q;
  assign mispredict  = mispredict_q;
  assign inflight    = inflight_q;
  assign total_count = total_q;
  assign miss_count  = miss_q;
  assign error       = error_q;

endmodule

// File: tb/tb_branch_resolve_tracker.sv
// Directed bench for branch_resolve_tracker with a 3-bit counter build so
// saturation is reachable in a handful of branches.
module tb_branch_resolve_tracker;

  localparam int AB = 4;
  localparam int DP = 4;
  localparam int CB = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          pred_valid;
  logic [AB-1:0] pred_address;
  logic          pred_taken;
  logic          pred_ready;
  logic          resolve_valid;
  logic          resolve_taken;
  logic          upd_valid;
  logic [AB-1:0] upd_address;
  logic          upd_taken;
  logic          mispredict;
  logic [2:0]    inflight;
  logic [CB-1:0] total_count;
  logic [CB-1:0] miss_count;
  logic          error;

  int n_checks = 0;
  int n_fail   = 0;

  branch_resolve_tracker #(.ADDRESS_BITS(AB), .DEPTH(DP), .COUNT_BITS(CB)) dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_address(pred_address), .pred_taken(pred_taken),
    .pred_ready(pred_ready),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .upd_valid(upd_valid), .upd_address(upd_address), .upd_taken(upd_taken),
    .mispredict(mispredict), .inflight(inflight),
    .total_count(total_count), .miss_count(miss_count), .error(error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pred_valid = 1'b0; resolve_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; idle(); pred_address = '0; pred_taken = 1'b0; resolve_taken = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    n_checks++; if (pred_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0b want 1", pred_ready); end
    n_checks++; if (inflight !== 3'd0) begin n_fail++; $display("FAIL reset_inflight got %0d want 0", inflight); end
    n_checks++; if (upd_valid !== 1'b0 || mispredict !== 1'b0) begin n_fail++; $display("FAIL reset_pulses got upd=%0b mis=%0b want 0 0", upd_valid, mispredict); end
    n_checks++; if (total_count !== 3'd0 || miss_count !== 3'd0 || error !== 1'b0) begin n_fail++; $display("FAIL reset_stats got tot=%0d miss=%0d err=%0b want 0 0 0", total_count, miss_count, error); end
  endtask

  task automatic test_basic();
    pred_valid = 1'b1; pred_address = 4'd3; pred_taken = 1'b1; tick();
    pred_address = 4'd5; pred_taken = 1'b0; tick();
    pred_valid = 1'b0;
    n_checks++; if (inflight !== 3'd2) begin n_fail++; $display("FAIL basic_fill got %0d want 2", inflight); end
    resolve_valid = 1'b1; resolve_taken = 1'b1; tick();
    n_checks++; if ({upd_valid, upd_address, upd_taken, mispredict} !== {1'b1, 4'd3, 1'b1, 1'b0}) begin n_fail++; $display("FAIL basic_upd0 got v=%0b a=%0d t=%0b m=%0b want 1 3 1 0", upd_valid, upd_address, upd_taken, mispredict); end
    resolve_taken = 1'b0; tick();
    n_checks++; if ({upd_valid, upd_address, upd_taken, mispredict} !== {1'b1, 4'd5, 1'b0, 1'b0}) begin n_fail++; $display("FAIL basic_upd1 got v=%0b a=%0d t=%0b m=%0b want 1 5 0 0", upd_valid, upd_address, upd_taken, mispredict); end
    resolve_valid = 1'b0; tick();
    n_checks++; if (upd_valid !== 1'b0 || upd_address !== 4'd5) begin n_fail++; $display("FAIL basic_hold got v=%0b a=%0d want 0 5", upd_valid, upd_address); end
    n_checks++; if (total_count !== 3'd2 || miss_count !== 3'd0 || inflight !== 3'd0) begin n_fail++; $display("FAIL basic_stats got tot=%0d miss=%0d inf=%0d want 2 0 0", total_count, miss_count, inflight); end
  endtask

  task automatic test_full();
    logic [AB-1:0] exp_addr [4];
    exp_addr[0] = 4'd2; exp_addr[1] = 4'd3; exp_addr[2] = 4'd4; exp_addr[3] = 4'd11;
    pred_valid = 1'b1; pred_taken = 1'b0;
    for (int i = 1; i <= 4; i++) begin pred_address = AB'(i); tick(); end
    n_checks++; if (inflight !== 3'd4 || pred_ready !== 1'b0) begin n_fail++; $display("FAIL full_state got inf=%0d rdy=%0b want 4 0", inflight, pred_ready); end
    pred_address = 4'd15; tick();
    n_checks++; if (inflight !== 3'd4) begin n_fail++; $display("FAIL full_drop got %0d want 4", inflight); end
    pred_address = 4'd10; resolve_valid = 1'b1; resolve_taken = 1'b0; tick();
    n_checks++; if (inflight !== 3'd3 || upd_address !== 4'd1 || upd_valid !== 1'b1) begin n_fail++; $display("FAIL full_nobypass got inf=%0d a=%0d v=%0b want 3 1 1", inflight, upd_address, upd_valid); end
    resolve_valid = 1'b0; pred_address = 4'd11; tick();
    n_checks++; if (inflight !== 3'd4) begin n_fail++; $display("FAIL full_refill got %0d want 4", inflight); end
    pred_valid = 1'b0; resolve_valid = 1'b1; resolve_taken = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (upd_valid !== 1'b1 || upd_address !== exp_addr[i] || mispredict !== 1'b0) begin n_fail++; $display("FAIL full_drain%0d got v=%0b a=%0d m=%0b want 1 %0d 0", i, upd_valid, upd_address, mispredict, exp_addr[i]); end
    end
    resolve_valid = 1'b0; tick();
    n_checks++; if (total_count !== 3'd7 || inflight !== 3'd0) begin n_fail++; $display("FAIL full_total got tot=%0d inf=%0d want 7 0", total_count, inflight); end
  endtask

  task automatic test_mispredict();
    pred_valid = 1'b1;
    pred_address = 4'd7; pred_taken = 1'b1; tick();
    pred_address = 4'd8; pred_taken = 1'b1; tick();
    pred_address = 4'd9; pred_taken = 1'b0; tick();
    pred_address = 4'd12; pred_taken = 1'b1; resolve_valid = 1'b1; resolve_taken = 1'b0; tick();
    n_checks++; if ({upd_valid, upd_address, upd_taken, mispredict} !== {1'b1, 4'd7, 1'b0, 1'b1}) begin n_fail++; $display("FAIL mis_upd got v=%0b a=%0d t=%0b m=%0b want 1 7 0 1", upd_valid, upd_address, upd_taken, mispredict); end
    n_checks++; if (inflight !== 3'd0 || pred_ready !== 1'b0 || miss_count !== 3'd1) begin n_fail++; $display("FAIL mis_flush got inf=%0d rdy=%0b miss=%0d want 0 0 1", inflight, pred_ready, miss_count); end
    pred_valid = 1'b0; tick();
    n_checks++; if (upd_valid !== 1'b0 || mispredict !== 1'b0 || pred_ready !== 1'b1) begin n_fail++; $display("FAIL mis_after got v=%0b m=%0b rdy=%0b want 0 0 1", upd_valid, mispredict, pred_ready); end
    n_checks++; if (error !== 1'b0 || inflight !== 3'd0 || miss_count !== 3'd1 || total_count !== 3'd7) begin n_fail++; $display("FAIL mis_ignore got err=%0b inf=%0d miss=%0d tot=%0d want 0 0 1 7", error, inflight, miss_count, total_count); end
    resolve_valid = 1'b0; tick();
  endtask

  task automatic test_error();
    pred_valid = 1'b1; pred_address = 4'd6; pred_taken = 1'b1; resolve_valid = 1'b1; resolve_taken = 1'b1; tick();
    n_checks++; if (error !== 1'b1 || upd_valid !== 1'b0 || inflight !== 3'd1) begin n_fail++; $display("FAIL err_set got err=%0b v=%0b inf=%0d want 1 0 1", error, upd_valid, inflight); end
    idle(); tick();
    n_checks++; if (error !== 1'b1 || total_count !== 3'd7 || miss_count !== 3'd1) begin n_fail++; $display("FAIL err_sticky got err=%0b tot=%0d miss=%0d want 1 7 1", error, total_count, miss_count); end
    resolve_valid = 1'b1; resolve_taken = 1'b1; tick();
    n_checks++; if (upd_valid !== 1'b1 || upd_address !== 4'd6 || mispredict !== 1'b0) begin n_fail++; $display("FAIL err_pop got v=%0b a=%0d m=%0b want 1 6 0", upd_valid, upd_address, mispredict); end
    idle(); tick();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 7; i++) begin
      pred_valid = 1'b1; pred_address = 4'd13; pred_taken = 1'b0; tick();
      pred_valid = 1'b0; resolve_valid = 1'b1; resolve_taken = 1'b1; tick();
      n_checks++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL sat_pulse%0d got %0b want 1", i, mispredict); end
      resolve_valid = 1'b0; tick();
    end
    n_checks++; if (miss_count !== 3'd7 || total_count !== 3'd7) begin n_fail++; $display("FAIL sat_counts got miss=%0d tot=%0d want 7 7", miss_count, total_count); end
  endtask

  task automatic test_reset_mid();
    pred_valid = 1'b1; pred_taken = 1'b1; pred_address = 4'd1; tick();
    pred_address = 4'd2; tick();
    pred_valid = 1'b0;
    n_checks++; if (inflight !== 3'd2) begin n_fail++; $display("FAIL rmid_fill got %0d want 2", inflight); end
    resolve_valid = 1'b1; resolve_taken = 1'b1;
    #2 reset = 1'b0;
    #1;
    n_checks++; if (inflight !== 3'd0 || total_count !== 3'd0 || miss_count !== 3'd0 || error !== 1'b0) begin n_fail++; $display("FAIL rmid_clear got inf=%0d tot=%0d miss=%0d err=%0b want 0 0 0 0", inflight, total_count, miss_count, error); end
    tick();
    idle(); reset = 1'b1; tick();
    n_checks++; if (upd_valid !== 1'b0 || inflight !== 3'd0 || pred_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_noupd got v=%0b inf=%0d rdy=%0b want 0 0 1", upd_valid, inflight, pred_ready); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_mispredict();
    test_error();
    test_saturation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
